// File: rtl/list_sum_datapath.sv
// Datapath for the linked-list summation engine: node memory, SUM/NEXT registers and the muxes
// steered by the list-sum controller, plus result/status outputs for the board top.
module list_sum_datapath #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_sum,
   input  logic              ld_next,
   input  logic              sum_sel,
   input  logic              next_sel,
   input  logic              a_sel,
   input  logic              done,
   output logic              next_zero,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_waddr,
   input  logic [WIDTH-1:0]  mem_wdata,
   output logic [WIDTH-1:0]  sum_out,
   output logic              sum_valid,
   output logic              overflow,
   output logic [ADDR_W-1:0] node_count
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [WIDTH-1:0]  mem_q [Depth];
   logic [ADDR_W-1:0] raddr;
   logic [WIDTH-1:0]  rdata;

   logic [WIDTH-1:0]  sum_q, sum_d;
   logic [ADDR_W-1:0] next_q, next_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              valid_q;
   logic              carry;
   logic [WIDTH-1:0]  sum_add;

   // Write-after-read: the async read sees the old word until the edge commits the write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_comb begin
      raddr = a_sel ? next_q : next_q + ADDR_W'(1);
      rdata = mem_q[raddr];
   end

   always_comb begin
      {carry, sum_add} = {1'b0, sum_q} + {1'b0, rdata};
      sum_d  = sum_sel ? sum_add : '0;
      next_d = next_sel ? rdata[ADDR_W-1:0] : '0;
      ovf_d  = ovf_q;
      cnt_d  = cnt_q;
      if (ld_sum) begin
         if (sum_sel) begin
            ovf_d = ovf_q | carry;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end else begin
            ovf_d = 1'b0;
            cnt_d = '0;
         end
      end
   end

   // Lookahead on the value being loaded so the controller can decide on this same edge.
   assign next_zero = (next_d == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         next_q  <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (ld_sum) begin
            sum_q <= sum_d;
         end
         if (ld_next) begin
            next_q <= next_d;
         end
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         valid_q <= done;
      end
   end

   assign sum_out    = sum_q;
   assign sum_valid  = valid_q;
   assign overflow   = ovf_q;
   assign node_count = cnt_q;

endmodule

// File: tb/tb_list_sum_datapath.sv
// Directed bench for list_sum_datapath: results are queued when a run is issued and a
// monitor checks them when sum_valid rises; intermediate status is checked inline.
module tb_list_sum_datapath;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              ld_sum, ld_next, sum_sel, next_sel, a_sel, done;
   logic              next_zero;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WIDTH-1:0]  mem_wdata;
   logic [WIDTH-1:0]  sum_out;
   logic              sum_valid;
   logic              overflow;
   logic [ADDR_W-1:0] node_count;

   typedef struct packed {
      logic [WIDTH-1:0]  sum;
      logic [ADDR_W-1:0] cnt;
      logic              ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic valid_prev = 1'b0;

   list_sum_datapath #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .ld_sum     (ld_sum),
      .ld_next    (ld_next),
      .sum_sel    (sum_sel),
      .next_sel   (next_sel),
      .a_sel      (a_sel),
      .done       (done),
      .next_zero  (next_zero),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .sum_out    (sum_out),
      .sum_valid  (sum_valid),
      .overflow   (overflow),
      .node_count (node_count)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end else begin
         n_pass++;
      end
   endfunction

   // Monitor: one queued result per rising sum_valid.
   always @(negedge clk) begin
      if (sum_valid === 1'b1 && !valid_prev) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(exp_q.size()), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("result_sum", 32'(sum_out), 32'(e.sum));
            check("result_count", 32'(node_count), 32'(e.cnt));
            check("result_overflow", 32'(overflow), 32'(e.ovf));
         end
      end
      valid_prev = (sum_valid === 1'b1);
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctrl(input logic [5:0] c);
      {ld_sum, ld_next, sum_sel, next_sel, a_sel, done} = c;
   endtask

   task automatic wr(input int a, input int d);
      mem_we    = 1'b1;
      mem_waddr = a[ADDR_W-1:0];
      mem_wdata = d[WIDTH-1:0];
      tick();
      mem_we = 1'b0;
   endtask

   task automatic do_reset;
      set_ctrl(6'b000000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic compute;
      set_ctrl(6'b101110);
      tick();
   endtask

   task automatic get_next(input logic nz);
      set_ctrl(6'b011100);
      #1;
      check("next_zero", 32'(next_zero), 32'(nz));
      tick();
   endtask

   task automatic finish_run;
      set_ctrl(6'b000001);
      #1;
      check("valid_lag", 32'(sum_valid), 0);
      tick();
      set_ctrl(6'b000000);
      tick();
      tick();
   endtask

   initial begin
      rst       = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      set_ctrl(6'b000000);
      tick();

      // Two-node list: 5 + 7
      wr(0, 5); wr(1, 4); wr(4, 7); wr(5, 0);
      do_reset();
      check("reset_sum", 32'(sum_out), 0);
      check("reset_count", 32'(node_count), 0);
      check("reset_overflow", 32'(overflow), 0);
      check("reset_valid", 32'(sum_valid), 0);
      exp_q.push_back('{sum: 8'd12, cnt: 8'd2, ovf: 1'b0});
      compute(); get_next(1'b0); compute(); get_next(1'b1);
      finish_run();

      // Single node
      wr(0, 9); wr(1, 0);
      do_reset();
      exp_q.push_back('{sum: 8'd9, cnt: 8'd1, ovf: 1'b0});
      compute(); get_next(1'b1);
      finish_run();

      // Overflow: 200 + 100 = 300 -> 44 with carry
      wr(0, 200); wr(1, 2); wr(2, 100); wr(3, 0);
      do_reset();
      exp_q.push_back('{sum: 8'd44, cnt: 8'd2, ovf: 1'b1});
      compute();
      check("ovf_first_add", 32'(overflow), 0);
      get_next(1'b0);
      compute();
      check("ovf_second_add", 32'(overflow), 1);
      check("ovf_sum", 32'(sum_out), 44);
      get_next(1'b1);
      finish_run();
      // A clearing load (ld_sum, sum_sel=0) drops SUM, overflow and count
      set_ctrl(6'b100000);
      tick();
      check("clear_sum", 32'(sum_out), 0);
      check("clear_overflow", 32'(overflow), 0);
      check("clear_count", 32'(node_count), 0);

      // Address wrap: node at 255 takes its pointer from mem[0]
      wr(0, 10); wr(1, 255); wr(255, 3); wr(10, 1); wr(11, 0);
      do_reset();
      exp_q.push_back('{sum: 8'd14, cnt: 8'd3, ovf: 1'b0});
      compute(); get_next(1'b0); compute(); get_next(1'b0); compute(); get_next(1'b1);
      finish_run();

      // Reset mid-run, with loads asserted to show reset priority
      do_reset();
      compute();
      rst = 1'b1;
      set_ctrl(6'b111110);
      tick();
      rst = 1'b0;
      check("midrst_sum", 32'(sum_out), 0);
      check("midrst_count", 32'(node_count), 0);
      check("midrst_overflow", 32'(overflow), 0);
      exp_q.push_back('{sum: 8'd14, cnt: 8'd3, ovf: 1'b0});
      compute();
      check("midrst_next_zeroed", 32'(sum_out), 10);
      check("midrst_recount", 32'(node_count), 1);
      get_next(1'b0); compute(); get_next(1'b0); compute(); get_next(1'b1);
      finish_run();

      // Same-address write and read: NEXT must take the old mem[1] (255)
      wr(6, 2); wr(7, 0);
      do_reset();
      exp_q.push_back('{sum: 8'd5, cnt: 8'd2, ovf: 1'b0});
      mem_we    = 1'b1;
      mem_waddr = 8'd1;
      mem_wdata = 8'd6;
      get_next(1'b0);
      mem_we = 1'b0;
      compute();
      check("rdw_old_data", 32'(sum_out), 3);
      set_ctrl(6'b010000);
      tick();
      get_next(1'b0);
      compute();
      check("rdw_new_data", 32'(sum_out), 5);
      get_next(1'b1);
      finish_run();

      check("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/list_sum_datapath.md
Name: list_sum_datapath

Overview:
- Datapath for the linked-list summation engine: node memory, SUM and NEXT registers, address and load muxes.
- Driven cycle-by-cycle by the list-sum FSM controller through ld_sum, ld_next, sum_sel, next_sel, a_sel and done.
- Returns next_zero to that controller.
- Exposes a write port for host preload of the list, and a result/status interface consumed by the board top.

Parameters:
- WIDTH, 8: memory word and SUM width. Must satisfy WIDTH >= ADDR_W.
- ADDR_W, 8: memory address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- ld_sum  in  1  load SUM register this edge
- ld_next  in  1  load NEXT register this edge
- sum_sel  in  1  1: SUM_d = SUM + rdata; 0: SUM_d = 0
- next_sel  in  1  1: NEXT_d = rdata[ADDR_W-1:0]; 0: NEXT_d = 0
- a_sel  in  1  1: raddr = NEXT (node value); 0: raddr = NEXT+1 (node pointer)
- done  in  1  controller done flag
- next_zero  out  1  combinational: NEXT_d == 0
- mem_we  in  1  host write enable
- mem_waddr  in  ADDR_W  host write address
- mem_wdata  in  WIDTH  host write data
- sum_out  out  WIDTH  SUM register
- sum_valid  out  1  registered copy of done
- overflow  out  1  sticky carry-out of SUM accumulation
- node_count  out  ADDR_W  nodes accumulated, saturating

Behaviour:
- List format:
  - Node at address a: value at mem[a], pointer at mem[(a+1) mod DEPTH] (low ADDR_W bits).
  - Pointer 0 terminates the list.
  - The head node is always at address 0.
- Memory:
  - DEPTH x WIDTH, asynchronous read at raddr, synchronous write on mem_we.
  - Not cleared by rst. Initial contents undefined.
  - A write and a read to the same address in the same cycle: read returns the old data; the new data is visible from the next cycle.
  - Host writes are accepted at any time; the host must not write while a sum is in progress.
- raddr: a_sel ? NEXT : NEXT+1, in ADDR_W-bit arithmetic. NEXT = DEPTH-1 with a_sel=0 wraps to address 0.
- SUM_d:
  - sum_sel ? SUM + rdata : 0, truncated to WIDTH bits.
  - Loaded on the edge when ld_sum=1.
- NEXT_d:
  - next_sel ? rdata[ADDR_W-1:0] : 0.
  - Loaded on the edge when ld_next=1.
- next_zero: purely combinational lookahead on NEXT_d, so the controller sees the pointer being loaded on the same edge it decides. It is not based on the current NEXT value.
- overflow:
  - Set on an edge with ld_sum=1, sum_sel=1 and a carry out of the WIDTH-bit add.
  - Cleared on an edge with ld_sum=1 and sum_sel=0, or on rst.
  - Otherwise holds.
- node_count:
  - +1 on each edge with ld_sum=1 and sum_sel=1.
  - Saturates at 2**ADDR_W-1, no wrap.
  - Cleared on an edge with ld_sum=1 and sum_sel=0, or on rst.
- sum_valid: equals done delayed by one cycle. sum_out is stable while sum_valid=1, because the controller loads nothing in DONE.
- ld_sum and ld_next both high: both registers load in the same edge from the same rdata.
- Reset (rst=1 at an edge, including mid-run):
  - SUM=0, NEXT=0, overflow=0, node_count=0, sum_valid=0.
  - Memory untouched.
  - rst takes priority over all load inputs.
- Run protocol: the host asserts rst between runs. The controller never clears SUM itself.
- Cyclic lists are not detected. The computation does not terminate and node_count saturates.

Test Plan:
- Preload mem[0]=5, mem[1]=4, mem[4]=7, mem[5]=0; rst; drive the controller sequence (101110, 011100 x2) -> sum_out=12, node_count=2, next_zero=1 during the second GET_NEXT, sum_valid=1 one cycle after done, overflow=0.
- Single node: mem[0]=9, mem[1]=0 -> next_zero=1 in the first GET_NEXT, sum_out=9, node_count=1.
- Overflow, WIDTH=8: mem[0]=200, mem[1]=2, mem[2]=100, mem[3]=0 -> sum_out=44, overflow=1 after the second add and remaining 1 through DONE.
- Wrap: ADDR_W=8, node at 255 (mem[255]=3), pointer read from mem[0] -> raddr=0 when NEXT=255 and a_sel=0; NEXT_d=mem[0].
- rst asserted mid-run after the first COMPUTE_SUM -> SUM=0, NEXT=0, node_count=0 on the next cycle; memory contents unchanged on readback.
- Same-address write/read: mem_we to address 1 with value 6 while a_sel=0 and NEXT=0 -> NEXT loads the old mem[1]; the next cycle reads 6.
